// File: rtl/if_stage_pipelined.sv
// ---------------------------------------------------------------------------
// if_stage_pipelined
//
// Instruction-fetch stage for the MIPS pipeline. Owns the PC, presents the
// program-ROM address as a byte offset from TEXT_BASE, and captures the
// fetched instruction, its PC and PC+4 into the IF/ID register together with
// valid/fault flags. Supports stall, flush, redirect, and a small FSM that
// halts fetch after a faulted slot and resumes only on a redirect.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-high
//   stall_i        hold PC and IF/ID
//   flush_i        bubble IF/ID on the next edge
//   redirect_i     load redirect_pc_i into the PC (branch/jump/vector)
//   redirect_pc_i  redirect target
//   imem_rdata_i   ROM data, combinational from imem_addr_o
//   imem_addr_o    pc_o - TEXT_BASE (byte offset into the ROM)
//   pc_o           current PC
//   if_id_instr_o  registered instruction
//   if_id_pc_o     registered PC of that instruction
//   if_id_pc4_o    registered PC+4
//   if_id_valid_o  IF/ID holds a real instruction
//   if_id_fault_o  IF/ID slot faulted (misaligned or out of range)
//   halted_o       FSM is in HALT
//   perf_fetch_o   (IF_PERF_CNT_EN) count of valid IF/ID loads
//   perf_stall_o   (IF_PERF_CNT_EN) count of stalled cycles while running
//   fsm_state_o    debug view of the fetch FSM state
//
// Build option: define IF_PERF_CNT_EN to add the two performance counters
// and their ports. Without it the counters and ports are absent and all
// other behaviour is identical.
// ---------------------------------------------------------------------------
module if_stage_pipelined #(
    parameter int               NBits        = 32,
    parameter int               MEMORY_DEPTH = 512,
    parameter logic [NBits-1:0] TEXT_BASE    = 32'h0040_0000,
    parameter logic [NBits-1:0] RESET_PC     = TEXT_BASE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             redirect_i,
    input  logic [NBits-1:0] redirect_pc_i,
    input  logic [NBits-1:0] imem_rdata_i,
    output logic [NBits-1:0] imem_addr_o,
    output logic [NBits-1:0] pc_o,
    output logic [NBits-1:0] if_id_instr_o,
    output logic [NBits-1:0] if_id_pc_o,
    output logic [NBits-1:0] if_id_pc4_o,
    output logic             if_id_valid_o,
    output logic             if_id_fault_o,
    output logic             halted_o,
`ifdef IF_PERF_CNT_EN
    output logic [NBits-1:0] perf_fetch_o,
    output logic [NBits-1:0] perf_stall_o,
`endif
    output logic [1:0]       fsm_state_o
);

    // IF/ID slot semantics: if_id_valid_o=1 means the slot carries a real
    // instruction for decode. While stall_i=1 (and no redirect/flush) the slot
    // and the PC hold, so decode sees the same instruction again; a slot is
    // consumed only on an edge where stall_i=0.

    localparam logic [NBits-1:0] ROM_BYTES = NBits'(MEMORY_DEPTH * 4);
    localparam logic [NBits-1:0] PC_STEP   = NBits'(4);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [NBits-1:0] pc;
    logic [NBits-1:0] pc_plus4;
    logic [NBits-1:0] offset;
    logic             fault_now;
    logic             fetch_block;
    logic             load_fault;
    logic             load_valid;

    // Offset is computed with NBits wrap, so a PC below TEXT_BASE becomes a
    // huge offset and trips the range check rather than aliasing into the ROM.
    assign offset      = pc - TEXT_BASE;
    assign pc_plus4    = pc + PC_STEP;
    assign fault_now   = (pc[1:0] != 2'b00) | (offset >= ROM_BYTES);
    assign fetch_block = redirect_i | flush_i | (state != S_RUN);
    assign load_fault  = ~fetch_block & ~stall_i & fault_now;
    assign load_valid  = ~fetch_block & ~stall_i & ~fault_now;

    assign imem_addr_o = offset;
    assign pc_o        = pc;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_BOOT;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state;
        case (state)
            S_BOOT:  state_next = S_RUN;
            S_RUN:   state_next = load_fault ? S_HALT : S_RUN;
            S_HALT:  state_next = redirect_i ? S_RUN : S_HALT;
            default: state_next = S_BOOT;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        halted_o    = 1'b0;
        fsm_state_o = state;
        if (state == S_HALT) begin
            halted_o = 1'b1;
        end
    end

    // ---------------- PC ----------------
    // Redirect beats stall; BOOT and HALT hold the PC like a stall. In RUN
    // the PC still advances past a faulting address on the edge that loads
    // the fault, then freezes in HALT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (redirect_i) begin
            pc <= redirect_pc_i;
        end else if (!stall_i && state == S_RUN) begin
            pc <= pc_plus4;
        end
    end

    // ---------------- IF/ID register ----------------
    // On bubbles the pc/pc4 fields are left as they were; they carry no
    // meaning while valid and fault are both low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_id_instr_o <= '0;
            if_id_pc_o    <= '0;
            if_id_pc4_o   <= '0;
            if_id_valid_o <= 1'b0;
            if_id_fault_o <= 1'b0;
        end else if (fetch_block) begin
            if_id_instr_o <= '0;
            if_id_valid_o <= 1'b0;
            if_id_fault_o <= 1'b0;
        end else if (stall_i) begin
            if_id_instr_o <= if_id_instr_o;
        end else if (fault_now) begin
            if_id_instr_o <= '0;
            if_id_pc_o    <= pc;
            if_id_pc4_o   <= pc_plus4;
            if_id_valid_o <= 1'b0;
            if_id_fault_o <= 1'b1;
        end else begin
            if_id_instr_o <= imem_rdata_i;
            if_id_pc_o    <= pc;
            if_id_pc4_o   <= pc_plus4;
            if_id_valid_o <= 1'b1;
            if_id_fault_o <= 1'b0;
        end
    end

`ifdef IF_PERF_CNT_EN
    // ---------------- Performance counters ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetch_o <= '0;
            perf_stall_o <= '0;
        end else begin
            if (load_valid) begin
                perf_fetch_o <= perf_fetch_o + NBits'(1);
            end
            if (stall_i && state == S_RUN) begin
                perf_stall_o <= perf_stall_o + NBits'(1);
            end
        end
    end
`endif

endmodule
